// File: rtl/inst_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage of the 5-stage MIPS
//   pipeline: redirect encodings driven by the decode controller, the fetch
//   FSM state encoding, reset defaults and the sequential PC helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package inst_fetch_stage_pkg;

    // Redirect request encodings on pc_src_ctrl.
    typedef enum logic [1:0] {
        PC_SRC_NEXT   = 2'b00,
        PC_SRC_JR     = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_BRANCH = 2'b11
    } pc_src_e;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DRAIN = 2'b11
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Update priority: clear (bubble) > hold when
//   disabled > load a fetched instruction > bubble. A bubble forces the
//   instruction to NOP_INST and drops valid but leaves the PC untouched.
//
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   clr_i    : synchronous clear to a bubble
//   en_i     : register enable
//   load_i   : an instruction is available and accepted this cycle
//   inst_i   : instruction word to load
//   pc_i     : PC of inst_i
//   inst_o   : registered instruction
//   pc_o     : registered PC
//   valid_o  : registered instruction is real (not a bubble)
// -----------------------------------------------------------------------------
module if_id_reg
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clr_i) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (en_i) begin
            if (load_i) begin
                inst_d  = inst_i;
                pc_d    = pc_i;
                valid_d = 1'b1;
            end else begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inst_q  <= NOP_INST;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage
//   Instruction-fetch stage. Owns the PC, runs a req/ack handshake to
//   instruction memory that tolerates wait states, and feeds the IF/ID
//   register consumed by decode. Redirects come from the decode controller
//   for the instruction currently in ID (no delay slot).
//
//   clk_i           : clock
//   rst_ni          : asynchronous active-low reset
//   if_rst_i        : synchronous flush of the IF stage
//   if_en_i         : IF stage enable
//   id_rst_i        : synchronous clear of IF/ID
//   id_en_i         : IF/ID enable
//   pc_src_ctrl_i   : redirect request (next/jr/jump/branch)
//   jr_target_i     : jr target
//   jump_target_i   : jump target
//   branch_target_i : taken-branch target
//   imem_req_o      : fetch request
//   imem_addr_o     : request address
//   imem_ack_i      : transfer complete this cycle
//   imem_rdata_i    : instruction data, valid with imem_ack_i
//   inst_id_o       : instruction in ID
//   pc_id_o         : PC of inst_id_o
//   pc_plus4_id_o   : pc_id_o + 4 (link value)
//   if_valid_o      : IF holds a usable instruction this cycle
//   id_valid_o      : inst_id_o is a real instruction
// -----------------------------------------------------------------------------
module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_rst_i,
    input  logic        if_en_i,
    input  logic        id_rst_i,
    input  logic        id_en_i,
    input  logic [1:0]  pc_src_ctrl_i,
    input  logic [31:0] jr_target_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_id_o,
    output logic [31:0] pc_id_o,
    output logic [31:0] pc_plus4_id_o,
    output logic        if_valid_o,
    output logic        id_valid_o
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] hold_buf_q;
    logic        hold_load;

    logic        id_valid;
    logic        redirect;
    logic        accept;
    logic        in_fetch;
    logic        in_hold;
    logic        in_drain;
    logic        outstanding;
    logic        inst_avail;
    logic        if_id_load;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic [31:0] if_inst;

    assign in_fetch = (state_q == ST_FETCH);
    assign in_hold  = (state_q == ST_HOLD);
    assign in_drain = (state_q == ST_DRAIN);

    // A redirect is only honoured for a real instruction that is actually
    // moving out of ID this cycle.
    assign redirect = id_valid & id_en_i & ~id_rst_i &
                      (pc_src_ctrl_i != PC_SRC_NEXT);
    assign accept   = if_en_i & id_en_i & ~id_rst_i & ~redirect;
    assign seq_pc   = pc_plus4(req_pc_q);

    always_comb begin
        case (pc_src_e'(pc_src_ctrl_i))
            PC_SRC_JR:     target = jr_target_i;
            PC_SRC_JUMP:   target = jump_target_i;
            PC_SRC_BRANCH: target = branch_target_i;
            default:       target = seq_pc;
        endcase
    end

    // A transfer is still in flight this cycle (request up, no ack yet).
    assign outstanding = (in_fetch | in_drain) & ~imem_ack_i;

    // The IF flush suppresses delivery of whatever IF holds this cycle.
    assign inst_avail = ((in_fetch & imem_ack_i) | in_hold) & ~if_rst_i;
    assign if_id_load = accept & inst_avail;
    assign if_inst    = in_hold ? hold_buf_q : imem_rdata_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        hold_load = 1'b0;
        case (state_q)
            ST_START: begin
                if (if_en_i) begin
                    state_d  = ST_FETCH;
                    req_pc_d = pc_q;
                end
            end
            ST_FETCH: begin
                if (imem_ack_i) begin
                    if (redirect) begin
                        pc_d     = target;
                        req_pc_d = target;
                    end else if (accept) begin
                        pc_d     = seq_pc;
                        req_pc_d = seq_pc;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect) begin
                    // The wrong-path request must still complete; remember
                    // where to go once it does.
                    pc_d    = target;
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d     = target;
                    req_pc_d = target;
                    state_d  = ST_FETCH;
                end else if (accept) begin
                    pc_d     = seq_pc;
                    req_pc_d = seq_pc;
                    state_d  = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // Address stays put until ack; only the pending PC moves.
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack_i) begin
                    req_pc_d = pc_d;
                    state_d  = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        if (if_rst_i) begin
            pc_d      = RESET_PC;
            hold_load = 1'b0;
            if (outstanding) begin
                // Let the in-flight transfer finish; DRAIN then fetches pc.
                state_d  = ST_DRAIN;
                req_pc_d = req_pc_q;
            end else begin
                state_d  = ST_START;
                req_pc_d = RESET_PC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_START;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Data-only buffer: meaningful only while in HOLD, so no reset.
    always_ff @(posedge clk_i) begin
        if (hold_load) begin
            hold_buf_q <= imem_rdata_i;
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (id_rst_i),
        .en_i    (id_en_i),
        .load_i  (if_id_load),
        .inst_i  (if_inst),
        .pc_i    (req_pc_q),
        .inst_o  (inst_id_o),
        .pc_o    (pc_id_o),
        .valid_o (id_valid)
    );

    assign imem_req_o    = in_fetch | in_drain;
    assign imem_addr_o   = req_pc_q;
    assign if_valid_o    = (in_fetch & imem_ack_i) | in_hold;
    assign id_valid_o    = id_valid;
    assign pc_plus4_id_o = pc_plus4(pc_id_o);

endmodule
